// File: rtl/fsm_counter.sv
// Start/skip-controlled up-counter run by a four-state Moore FSM; all outputs registered.
// Define FSM_COUNTER_SATURATE_EN to hold at MAX_COUNT instead of wrapping to zero.
module fsm_counter #(
   parameter int unsigned MAX_COUNT  = 15,
   parameter int unsigned SKIP_VALUE = 5
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   input  logic       skip,
   output logic       skip_to_five,
   output logic [7:0] count_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      SKIP  = 2'b10,
      PAUSE = 2'b11
   } state_e;

   localparam logic [7:0] MaxVal  = 8'(MAX_COUNT);
   localparam logic [7:0] SkipVal = 8'(SKIP_VALUE);

   state_e     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic       flag_q,  flag_d;

   logic skip_take;
   logic at_max;

   assign skip_take = skip && (count_q < SkipVal);
   assign at_max    = (count_q == MaxVal);

   // rstn is an active-high reset despite its name
   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q <= IDLE;
         count_q <= '0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         flag_q  <= flag_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = COUNT;
         COUNT: begin
            if (!start)         state_d = PAUSE;
            else if (skip_take) state_d = SKIP;
         end
         SKIP:    state_d = start ? COUNT : PAUSE;
         PAUSE:   if (start) state_d = COUNT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (state_q == COUNT) begin
         if (!start) begin
            count_d = count_q;
         end else if (skip_take) begin
            count_d = SkipVal;
         end else if (at_max) begin
`ifdef FSM_COUNTER_SATURATE_EN
            count_d = count_q;
`else
            count_d = '0;
`endif
         end else begin
            count_d = count_q + 8'd1;
         end
      end else if (state_q == SKIP && start) begin
         count_d = SkipVal + 8'd1;
      end
      flag_d = (state_d == SKIP);
   end

   assign count_out    = count_q;
   assign skip_to_five = flag_q;

endmodule

// File: tb/tb_fsm_counter.sv
// Directed and random stimulus for fsm_counter, checked against a run/hold/skip behavioural model.
module tb_fsm_counter;

   localparam int MAXC = 15;
   localparam int SKV  = 5;

   logic       clk;
   logic       rstn;
   logic       start;
   logic       skip;
   logic       skip_to_five;
   logic [7:0] count_out;

   int n_tests = 0;
   int n_fail  = 0;

   // model: counting = last edge left the block in a state where start keeps counting
   int m_cnt      = 0;
   bit m_flag     = 0;
   bit m_counting = 0;

   fsm_counter #(
      .MAX_COUNT (MAXC),
      .SKIP_VALUE(SKV)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .skip        (skip),
      .skip_to_five(skip_to_five),
      .count_out   (count_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_edge(input bit r, input bit s, input bit k);
      if (r) begin
         m_cnt = 0; m_flag = 0; m_counting = 0;
      end else if (m_flag) begin
         m_flag = 0;
         m_counting = s;
         if (s) m_cnt = SKV + 1;
      end else if (!m_counting) begin
         if (s) m_counting = 1;
      end else if (!s) begin
         m_counting = 0;
      end else if (k && m_cnt < SKV) begin
         m_cnt = SKV;
         m_flag = 1;
      end else if (m_cnt == MAXC) begin
`ifdef FSM_COUNTER_SATURATE_EN
         m_cnt = MAXC;
`else
         m_cnt = 0;
`endif
      end else begin
         m_cnt = m_cnt + 1;
      end
   endtask

   task automatic step(input bit r, input bit s, input bit k, input string tag);
      logic [7:0] exp_cnt;
      logic       exp_flag;
      rstn  = r;
      start = s;
      skip  = k;
      @(posedge clk);
      model_edge(r, s, k);
      #1;
      exp_cnt  = 8'(m_cnt);
      exp_flag = m_flag;
      n_tests++;
      assert (count_out === exp_cnt) else begin
         n_fail++;
         $error("FAIL %s count_out: got %0d expected %0d", tag, count_out, exp_cnt);
      end
      n_tests++;
      assert (skip_to_five === exp_flag) else begin
         n_fail++;
         $error("FAIL %s skip_to_five: got %0b expected %0b", tag, skip_to_five, exp_flag);
      end
   endtask

   initial begin
      rstn = 1'b1; start = 1'b0; skip = 1'b0;

      for (int i = 0; i < 10; i++) step(1, 0, 0, "reset");

      // run through wrap (or saturation)
      for (int i = 0; i < 20; i++) step(0, 1, 0, "wrap");

      // skip pulse at count 2
      step(1, 0, 0, "rst2");
      for (int i = 0; i < 3; i++) step(0, 1, 0, "to2");
      step(0, 1, 1, "skip_pulse");
      for (int i = 0; i < 3; i++) step(0, 1, 0, "after_skip");

      // skip held from count 8 is ignored
      for (int i = 0; i < 10; i++) step(0, 1, 1, "skip_late");

      // pause at 7 then resume
      step(1, 0, 0, "rst3");
      for (int i = 0; i < 8; i++) step(0, 1, 0, "to7");
      for (int i = 0; i < 10; i++) step(0, 0, 0, "pause");
      for (int i = 0; i < 4; i++) step(0, 1, 0, "resume");

      // skip held from start: one SKIP cycle, then no re-skip
      step(1, 0, 0, "rst4");
      for (int i = 0; i < 6; i++) step(0, 1, 1, "skip_held");

      // skip then pause from SKIP, then resume
      step(1, 0, 0, "rst5");
      step(0, 1, 0, "go");
      step(0, 1, 1, "skip0");
      step(0, 0, 0, "skip_pause");
      step(0, 0, 1, "pause_skip_ign");
      step(0, 1, 1, "resume_skip");
      step(0, 1, 0, "resume_inc");

      // reset during the SKIP cycle
      step(1, 0, 0, "rst6");
      for (int i = 0; i < 3; i++) step(0, 1, 0, "to2b");
      step(0, 1, 1, "skip_b");
      step(1, 1, 1, "rst_in_skip");
      step(0, 0, 1, "idle_skip_ign");

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0,
              $urandom_range(0, 3) == 0, "random");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
